or_unit_arbiter: RTL

//  Round-robin arbiter and sequencer that shares one registered 8-bit bitwise logic unit (AND/OR/XOR/NOR)

---
 rtl/or_unit_pkg.sv | 19 +
 rtl/logic_unit_reg.sv | 31 +++
 rtl/or_unit_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/or_unit_pkg.sv
// Shared types for the round-robin logic-unit arbiter: opcodes and FSM states.
package or_unit_pkg;

  // Opcode encoding as seen on req_op slices.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Sequencer states: wait for a request, run the unit, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic_unit_reg.sv
// Registered bitwise logic unit: y updates with op(a, b) on cycles where en is high.
module logic_unit_reg
  import or_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Compute and hold the result; y keeps its value while en is low.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!reset) begin
      y <= '0;
    end else if (en) begin
      unique case (op)
        OP_AND: y <= a & b;
        OP_OR:  y <= a | b;
        OP_XOR: y <= a ^ b;
        OP_NOR: y <= ~(a | b);
      endcase
    end
  end

endmodule

// File: rtl/or_unit_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered logic unit between NUM_REQ requesters.
// One op is in flight at a time: accept (IDLE) -> compute (EXEC) -> present result (RESP).
module or_unit_arbiter
  import or_unit_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_y
);

  state_e            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  int                grant_sel;
  int                search_idx;
  logic              accept;
  logic [ID_W-1:0]   next_ptr;

  op_e               cap_op;
  logic [WIDTH-1:0]  cap_a;
  logic [WIDTH-1:0]  cap_b;
  logic [ID_W-1:0]   cap_id;

  // Priority search for the first valid requester starting at rr_ptr, wrapping mod NUM_REQ.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    grant_any  = 1'b0;
    grant_idx  = '0;
    search_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(search_idx);
      end
    end
  end

  assign grant_sel = int'(grant_idx);
  assign accept    = (state == IDLE) && grant_any;
  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // One-hot accept strobe; gated by reset so it reads zero while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (accept && reset) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Sequencer FSM with operand capture, round-robin pointer update and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cap_op    <= OP_AND;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap_op <= op_e'(req_op[2*grant_sel +: 2]);
            cap_a  <= req_a[WIDTH*grant_sel +: WIDTH];
            cap_b  <= req_b[WIDTH*grant_sel +: WIDTH];
            cap_id <= grant_idx;
            rr_ptr <= next_ptr;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= cap_id;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The unit registers its result at the end of EXEC and holds it through RESP.
  logic_unit_reg #(.WIDTH(WIDTH)) u_logic_unit (
    .clock (clock),
    .reset (reset),
    .en    (state == EXEC),
    .op    (cap_op),
    .a     (cap_a),
    .b     (cap_b),
    .y     (rsp_y)
  );

endmodule
